mem_wb_pipe: RTL and testbench
==============================

Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline stage for the RISC-V core. It is the successor to the fixed 32-bit MEM/WB register.
- Adds a valid/ready handshake and a 2-entry skid buffer, so write-back can stall without dropping instructions.
- Adds flush, bubble-safe register-write gating, a pre-muxed write-back value and a retire counter.
- Sits between the data-memory stage and the register-file write port.

Parameters:
- XLEN, 32, data path width (read_data, alu_result, wb_data).
- REG_W, 5, register address width.
- CTRL_W, 2, WB control width; bit [CTRL_W-1] = regwrite, bit [0] = memtoreg; CTRL_W >= 2.
- CNT_W, 16, retire counter width.
- ZERO_GUARD, 1, when 1, suppress regwrite for destination register 0.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries.
- in_valid  in  1  MEM stage presents an entry.
- in_ready  out  1  stage can accept an entry this cycle.
- control_wb_in  in  CTRL_W  WB control bits.
- read_data_in  in  XLEN  memory load data.
- alu_result_in  in  XLEN  ALU result / address.
- write_reg_in  in  REG_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  write-back consumes head entry.
- regwrite  out  1  gated register write enable.
- memtoreg  out  1  head memtoreg bit.
- read_data  out  XLEN  head load data.
- mem_alu_result  out  XLEN  head ALU result.
- mem_write_reg  out  REG_W  head destination register.
- wb_data  out  XLEN  memtoreg ? read_data : mem_alu_result.
- retire_count  out  CNT_W  count of consumed entries.

Behaviour:
- Reset (synchronous, active-high): state EMPTY; out_valid=0, regwrite=0, memtoreg=0, read_data=0, mem_alu_result=0, mem_write_reg=0, wb_data=0, retire_count=0; skid contents cleared.
- in_ready = !reset && state != FULL. This is combinational from state only; it does not depend on out_ready.
- Accept: in_valid && in_ready at a rising edge. Consume: out_valid && out_ready at a rising edge.
- States: EMPTY (0 entries), ONE (head valid), FULL (head + skid valid). out_valid = state != EMPTY.
- EMPTY, accept: input goes to head, next state ONE. Accept-to-out_valid latency is 1 cycle.
- ONE, accept and consume: head <= input, stay ONE (1 entry/cycle throughput).
- ONE, accept without consume: skid <= input, next state FULL.
- ONE, consume without accept: next state EMPTY.
- FULL, consume: head <= skid, next state ONE. No accept is possible in FULL.
- FULL, no consume: hold. Head outputs stay stable while out_valid && !out_ready.
- Ordering is strictly FIFO; no entry is dropped or duplicated except by flush or reset.
- Flush: next state EMPTY, skid cleared. Any simultaneous accept is discarded.
- Flush and consume together: the consume counts toward retire_count; the entry is still discarded from the stage.
- Reset has priority over flush.
- Head data fields hold their last values when EMPTY.
- regwrite = out_valid && ctrl[CTRL_W-1] && !(ZERO_GUARD && mem_write_reg == 0). A bubble never writes.
- memtoreg follows the head ctrl[0], ungated.
- wb_data is combinational from the head registers. After reset it is 0 because all head fields are 0.
- retire_count increments by 1 on each consume and wraps modulo 2^CNT_W without saturation.
- Reset mid-operation: all entries are lost; in_ready is low during the reset cycle and high the next cycle.

Test Plan:
- Reset then idle: after reset, out_valid=0, regwrite=0, retire_count=0, in_ready=1. Then accept ctrl=2'b11, rd=x5, read_data=0xDEADBEEF, alu=0x10 → next cycle out_valid=1, regwrite=1, memtoreg=1, wb_data=0xDEADBEEF.
- Streaming: 8 back-to-back accepts with out_ready=1 → 8 consumes in order, one per cycle, in_ready never drops, retire_count=8.
- Stall/skid: out_ready=0 and accept A then B → state FULL, in_ready=0, head outputs hold A. Then out_ready=1 → A out, then B out, no loss.
- Flush in FULL while in_valid=1 with entry C → next cycle out_valid=0, in_ready=1, C never appears on the outputs.
- Zero guard: ctrl=2'b10, rd=0, alu=0x55 → regwrite=0 while out_valid=1 and wb_data=0x55. With rd=1 → regwrite=1.
- Counter wrap with CNT_W=4: 17 consumes → retire_count=1. Reset asserted mid-stream → retire_count=0 and out_valid=0 next cycle.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// mem_wb_pipe
//
// MEM/WB pipeline stage for the RISC-V core. It sits between the data-memory
// stage and the register-file write port. Entries move through it under a
// valid/ready handshake. A two-entry arrangement (head plus skid) lets
// write-back stall without dropping or duplicating instructions.
//
// Parameters
//   XLEN       data path width (read_data, alu_result, wb_data)
//   REG_W      register address width
//   CTRL_W     WB control width; [CTRL_W-1] = regwrite, [0] = memtoreg
//   CNT_W      retire counter width
//   ZERO_GUARD when 1, a write to register 0 never asserts regwrite
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   flush                    discard every held entry
//   in_valid / in_ready      upstream handshake from the MEM stage
//   control_wb_in, read_data_in, alu_result_in, write_reg_in
//                            fields of the incoming entry
//   out_valid / out_ready    downstream handshake to write-back
//   regwrite                 register write enable, gated by valid and reg 0
//   memtoreg                 memtoreg bit of the head entry
//   read_data, mem_alu_result, mem_write_reg
//                            fields of the head entry
//   wb_data                  pre-muxed write-back value
//   retire_count             number of consumed entries, wraps around
// ---------------------------------------------------------------------------
module mem_wb_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_W      = 5,
    parameter int CTRL_W     = 2,
    parameter int CNT_W      = 16,
    parameter int ZERO_GUARD = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] control_wb_in,
    input  logic [XLEN-1:0]   read_data_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [REG_W-1:0]  write_reg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              regwrite,
    output logic              memtoreg,
    output logic [XLEN-1:0]   read_data,
    output logic [XLEN-1:0]   mem_alu_result,
    output logic [REG_W-1:0]  mem_write_reg,
    output logic [XLEN-1:0]   wb_data,
    output logic [CNT_W-1:0]  retire_count
);

    // EMPTY: nothing held; ONE: head valid; FULL: head and skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [CTRL_W-1:0] head_ctrl;
    logic [XLEN-1:0]   head_read;
    logic [XLEN-1:0]   head_alu;
    logic [REG_W-1:0]  head_reg;

    logic [CTRL_W-1:0] skid_ctrl;
    logic [XLEN-1:0]   skid_read;
    logic [XLEN-1:0]   skid_alu;
    logic [REG_W-1:0]  skid_reg;

    logic accept;
    logic consume;
    logic load_head_in;
    logic load_head_skid;
    logic load_skid;
    logic clear_skid;

    // in_ready depends only on state (and reset), never on out_ready, so
    // the upstream stage sees no combinational path from write-back.
    assign in_ready  = !reset && (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath steering. Flush wins over any accept that
    // happens in the same cycle, so a flushed entry never lands.
    always_comb begin
        next_state     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        clear_skid     = 1'b0;

        if (flush) begin
            next_state = EMPTY;
            clear_skid = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_head_in = 1'b1;
                        next_state   = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_head_in = 1'b1;
                        next_state   = ONE;
                    end else if (accept) begin
                        load_skid  = 1'b1;
                        next_state = FULL;
                    end else if (consume) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        load_head_skid = 1'b1;
                        next_state     = ONE;
                    end
                end
                default: begin
                    next_state = EMPTY;
                end
            endcase
        end
    end

    // Head and skid storage. Head fields keep their last values when the
    // stage drains, so they only change on an explicit load.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_ctrl <= '0;
            head_read <= '0;
            head_alu  <= '0;
            head_reg  <= '0;
            skid_ctrl <= '0;
            skid_read <= '0;
            skid_alu  <= '0;
            skid_reg  <= '0;
        end else begin
            if (load_head_in) begin
                head_ctrl <= control_wb_in;
                head_read <= read_data_in;
                head_alu  <= alu_result_in;
                head_reg  <= write_reg_in;
            end else if (load_head_skid) begin
                head_ctrl <= skid_ctrl;
                head_read <= skid_read;
                head_alu  <= skid_alu;
                head_reg  <= skid_reg;
            end

            if (load_skid) begin
                skid_ctrl <= control_wb_in;
                skid_read <= read_data_in;
                skid_alu  <= alu_result_in;
                skid_reg  <= write_reg_in;
            end else if (clear_skid) begin
                skid_ctrl <= '0;
                skid_read <= '0;
                skid_alu  <= '0;
                skid_reg  <= '0;
            end
        end
    end

    // Retire counter. A consume that coincides with a flush still retires
    // the instruction, so it counts here even though the stage drops it.
    always_ff @(posedge clock) begin
        if (reset) begin
            retire_count <= '0;
        end else if (consume) begin
            retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // A bubble never writes. With the zero guard on, writes to x0 are
    // suppressed too, so the register file needs no x0 special case.
    always_comb begin
        regwrite = out_valid && head_ctrl[CTRL_W-1];
        if ((ZERO_GUARD != 0) && (head_reg == '0)) begin
            regwrite = 1'b0;
        end
    end

    assign memtoreg       = head_ctrl[0];
    assign read_data      = head_read;
    assign mem_alu_result = head_alu;
    assign mem_write_reg  = head_reg;
    assign wb_data        = head_ctrl[0] ? head_read : head_alu;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_pipe
//
// Directed bench for mem_wb_pipe with a 4-bit retire counter, so that the
// counter wraps quickly. Inputs change 1 time unit after each rising edge.
// Outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_mem_wb_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  control_wb_in;
    logic [31:0] read_data_in;
    logic [31:0] alu_result_in;
    logic [4:0]  write_reg_in;
    logic        out_valid;
    logic        out_ready;
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] read_data;
    logic [31:0] mem_alu_result;
    logic [4:0]  mem_write_reg;
    logic [31:0] wb_data;
    logic [3:0]  retire_count;

    int checks   = 0;
    int failures = 0;

    mem_wb_pipe #(
        .XLEN       (32),
        .REG_W      (5),
        .CTRL_W     (2),
        .CNT_W      (4),
        .ZERO_GUARD (1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .control_wb_in  (control_wb_in),
        .read_data_in   (read_data_in),
        .alu_result_in  (alu_result_in),
        .write_reg_in   (write_reg_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .regwrite       (regwrite),
        .memtoreg       (memtoreg),
        .read_data      (read_data),
        .mem_alu_result (mem_alu_result),
        .mem_write_reg  (mem_write_reg),
        .wb_data        (wb_data),
        .retire_count   (retire_count)
    );

    always #5 clock = ~clock;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one upstream entry onto the input bus.
    task automatic applyStimulus(input logic v, input logic [1:0] ctrl,
                                 input logic [4:0] rd, input logic [31:0] rdata,
                                 input logic [31:0] alu);
        in_valid      = v;
        control_wb_in = ctrl;
        write_reg_in  = rd;
        read_data_in  = rdata;
        alu_result_in = alu;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic clockCycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);

        // Reset state.
        clockCycle();
        clockCycle();
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_regwrite", {31'b0, regwrite}, 32'd0);
        checkOutput("rst_memtoreg", {31'b0, memtoreg}, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'h0);
        checkOutput("rst_retire", {28'b0, retire_count}, 32'd0);
        checkOutput("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // First accept: visible one cycle later.
        applyStimulus(1'b1, 2'b11, 5'd5, 32'hDEADBEEF, 32'h10);
        clockCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        checkOutput("first_out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("first_regwrite", {31'b0, regwrite}, 32'd1);
        checkOutput("first_memtoreg", {31'b0, memtoreg}, 32'd1);
        checkOutput("first_wb_data", wb_data, 32'hDEADBEEF);
        checkOutput("first_rd", {27'b0, mem_write_reg}, 32'd5);
        checkOutput("first_alu", mem_alu_result, 32'h10);
        out_ready = 1'b1;
        clockCycle();
        out_ready = 1'b0;
        checkOutput("first_drained", {31'b0, out_valid}, 32'd0);
        checkOutput("first_retire", {28'b0, retire_count}, 32'd1);

        // Streaming: 8 back-to-back entries, one per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'b10, 5'(i + 1), 32'h0, 32'h100 + i);
            checkOutput("stream_in_ready", {31'b0, in_ready}, 32'd1);
            clockCycle();
            checkOutput("stream_head_alu", mem_alu_result, 32'h100 + i);
            checkOutput("stream_out_valid", {31'b0, out_valid}, 32'd1);
        end
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        clockCycle();
        checkOutput("stream_drained", {31'b0, out_valid}, 32'd0);
        checkOutput("stream_retire", {28'b0, retire_count}, 32'd9);

        // Stall and skid: A then B with write-back stalled.
        out_ready = 1'b0;
        applyStimulus(1'b1, 2'b01, 5'd3, 32'hAAAA, 32'hA);
        clockCycle();
        applyStimulus(1'b1, 2'b11, 5'd4, 32'hBBBB, 32'hB);
        clockCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        checkOutput("full_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("full_head_alu", mem_alu_result, 32'hA);
        checkOutput("full_head_wb", wb_data, 32'hAAAA);
        checkOutput("full_regwrite", {31'b0, regwrite}, 32'd0);
        // An offer while FULL must be ignored.
        applyStimulus(1'b1, 2'b10, 5'd7, 32'h0, 32'hD);
        clockCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        checkOutput("hold_head_alu", mem_alu_result, 32'hA);
        checkOutput("hold_out_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        clockCycle();
        checkOutput("skid_head_alu", mem_alu_result, 32'hB);
        checkOutput("skid_wb", wb_data, 32'hBBBB);
        checkOutput("skid_regwrite", {31'b0, regwrite}, 32'd1);
        checkOutput("skid_in_ready", {31'b0, in_ready}, 32'd1);
        clockCycle();
        out_ready = 1'b0;
        checkOutput("skid_drained", {31'b0, out_valid}, 32'd0);
        checkOutput("skid_retire", {28'b0, retire_count}, 32'd11);

        // Flush in FULL with entry C offered at the same time.
        applyStimulus(1'b1, 2'b10, 5'd8, 32'h0, 32'hE);
        clockCycle();
        applyStimulus(1'b1, 2'b10, 5'd9, 32'h0, 32'hF);
        clockCycle();
        flush = 1'b1;
        applyStimulus(1'b1, 2'b10, 5'd10, 32'h0, 32'hC);
        clockCycle();
        flush = 1'b0;
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("flush_regwrite", {31'b0, regwrite}, 32'd0);
        checkOutput("flush_head_hold", mem_alu_result, 32'hE);
        checkOutput("flush_retire", {28'b0, retire_count}, 32'd11);
        clockCycle();
        checkOutput("flush_no_c", {31'b0, out_valid}, 32'd0);

        // Flush together with consume: counted, still discarded.
        applyStimulus(1'b1, 2'b10, 5'd11, 32'h0, 32'h77);
        clockCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        out_ready = 1'b1;
        flush     = 1'b1;
        clockCycle();
        flush     = 1'b0;
        out_ready = 1'b0;
        checkOutput("flushcons_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flushcons_retire", {28'b0, retire_count}, 32'd12);

        // Zero guard on x0, then a real write to x1.
        applyStimulus(1'b1, 2'b10, 5'd0, 32'h0, 32'h55);
        clockCycle();
        checkOutput("x0_regwrite", {31'b0, regwrite}, 32'd0);
        checkOutput("x0_out_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("x0_wb_data", wb_data, 32'h55);
        out_ready = 1'b1;
        applyStimulus(1'b1, 2'b10, 5'd1, 32'h0, 32'h66);
        clockCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        checkOutput("x1_regwrite", {31'b0, regwrite}, 32'd1);
        checkOutput("x1_wb_data", wb_data, 32'h66);
        checkOutput("x1_retire", {28'b0, retire_count}, 32'd13);
        clockCycle();
        checkOutput("x1_retire_after", {28'b0, retire_count}, 32'd14);

        // Counter wrap: 17 consumes after reset on a 4-bit counter.
        reset = 1'b1;
        clockCycle();
        reset = 1'b0;
        checkOutput("wrap_start", {28'b0, retire_count}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 2'b10, 5'd2, 32'h0, 32'h200 + i);
            clockCycle();
        end
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        checkOutput("wrap_last_head", mem_alu_result, 32'h210);
        clockCycle();
        checkOutput("wrap_retire", {28'b0, retire_count}, 32'd1);

        // Reset mid-stream with both entries held.
        out_ready = 1'b0;
        applyStimulus(1'b1, 2'b11, 5'd6, 32'h1234, 32'h300);
        clockCycle();
        applyStimulus(1'b1, 2'b11, 5'd7, 32'h5678, 32'h301);
        clockCycle();
        applyStimulus(1'b0, 2'b00, 5'd0, 32'h0, 32'h0);
        checkOutput("mid_full", {31'b0, in_ready}, 32'd0);
        reset = 1'b1;
        clockCycle();
        checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mid_rst_retire", {28'b0, retire_count}, 32'd0);
        checkOutput("mid_rst_regwrite", {31'b0, regwrite}, 32'd0);
        checkOutput("mid_rst_wb", wb_data, 32'h0);
        checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("mid_post_in_ready", {31'b0, in_ready}, 32'd1);
        clockCycle();
        checkOutput("mid_post_valid", {31'b0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
